// File: rtl/z16_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// z16_uart_tx_mmio
//
// Memory-mapped UART transmitter on the Z16 data-store path. CPU stores to
// TX_ADDR push the low byte of the store data into a small FIFO. A
// four-state FSM pops bytes and serialises them 8N1 (start, 8 data bits LSB
// first, stop) on o_tx. A status word is returned combinationally for the
// CPU load-select path whenever i_addr selects STAT_ADDR.
//
// Ports:
//   i_clk    in   1  system clock, rising edge
//   i_rst_n  in   1  asynchronous active-low reset
//   i_wen    in   1  CPU store strobe, one cycle per store
//   i_addr   in  16  CPU data address (ALU result)
//   i_wdata  in  16  CPU store data; [7:0] is transmitted, [2] clears overflow
//   o_rdata  out 16  status {13'b0, overflow, busy, full} at STAT_ADDR, else 0
//   o_tx     out  1  serial line, idle high, driven from a flop
//   o_busy   out  1  FIFO non-empty or frame in progress
//
// Store handshake: there is no back-pressure. A store strobe (i_wen with
// i_addr == TX_ADDR) is accepted on the rising edge where the FIFO is not
// full; "full" is taken from the pointers before that edge, so a same-edge
// pop never makes room for the push. A refused store is dropped and sets the
// sticky overflow bit, which a store to STAT_ADDR with bit 2 set clears.
// ---------------------------------------------------------------------------
module z16_uart_tx_mmio #(
    parameter int          CLK_HZ     = 27000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] TX_ADDR    = 16'h0078,
    parameter logic [15:0] STAT_ADDR  = 16'h0076
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wen,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int DIVISOR = CLK_HZ / BAUD;
    localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam int IDX_W   = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = IDX_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Store decode
    // ------------------------------------------------------------------
    logic push_req;
    logic push;
    logic drop;
    logic ovf_clr;
    logic pop;

    assign push_req = i_wen && (i_addr == TX_ADDR);
    assign ovf_clr  = i_wen && (i_addr == STAT_ADDR) && i_wdata[2];

    // Upper store byte is never transmitted.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^i_wdata[15:8];

    // ------------------------------------------------------------------
    // TX FIFO: pointers carry one extra wrap bit so full and empty are
    // distinguishable without a separate count.
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[IDX_W-1:0]];

    assign push = push_req && !fifo_full;
    assign drop = push_req && fifo_full;

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]] <= i_wdata[7:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    logic overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [CNT_W-1:0] baud_cnt_d;
    logic [2:0]       bit_idx_q;
    logic [2:0]       bit_idx_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             tx_q;
    logic             tx_d;
    logic             baud_tc;

    assign baud_tc = (baud_cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_head;
                    baud_cnt_d = CNT_ZERO;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    baud_cnt_d = CNT_ZERO;
                    bit_idx_d  = 3'd0;
                    state_d    = S_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    baud_cnt_d = CNT_ZERO;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    baud_cnt_d = CNT_ZERO;
                    state_d    = S_IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The line level is computed from the next state so the start bit
    // appears on the same edge that pops the byte.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tx   = tx_q;
    assign o_busy = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        o_rdata = 16'h0000;
        if (i_addr == STAT_ADDR) begin
            o_rdata = {13'b0, overflow, o_busy, fifo_full};
        end
    end

endmodule

// File: tb/tb_z16_uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// tb_z16_uart_tx_mmio
//
// Bench for z16_uart_tx_mmio with CLK_HZ=4, BAUD=1 (one bit = 4 cycles).
// The reference model keeps the FIFO contents as a byte queue and the
// current frame as (pop edge, byte); the expected line level is derived
// arithmetically from the distance to the pop edge.
// ---------------------------------------------------------------------------
module tb_z16_uart_tx_mmio;

    localparam int          D     = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * D;
    localparam logic [15:0] TX    = 16'h0078;
    localparam logic [15:0] ST    = 16'h0076;

    // ---------------- clock / reset ----------------
    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_wen   = 1'b0;
    logic [15:0] i_addr  = 16'h0000;
    logic [15:0] i_wdata = 16'h0000;
    logic [15:0] o_rdata;
    logic        o_tx;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    z16_uart_tx_mmio #(
        .CLK_HZ    (4),
        .BAUD      (1),
        .FIFO_DEPTH(DEPTH),
        .TX_ADDR   (TX),
        .STAT_ADDR (ST)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_wen  (i_wen),
        .i_addr (i_addr),
        .i_wdata(i_wdata),
        .o_rdata(o_rdata),
        .o_tx   (o_tx),
        .o_busy (o_busy)
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    int         m_start = -100000;
    logic [7:0] m_byte  = 8'h00;
    logic       m_ovf   = 1'b0;
    int         m_edge  = 0;
    int         n_vec   = 0;
    int         n_err   = 0;

    function automatic void model_reset();
        exp_q.delete();
        m_start = -100000;
        m_ovf   = 1'b0;
    endfunction

    function automatic logic m_frame_active();
        int d;
        d = m_edge - m_start;
        return (d >= 0) && (d < FRAME);
    endfunction

    function automatic logic m_tx_exp();
        int d;
        int k;
        d = m_edge - m_start;
        if (d < 0 || d >= FRAME) return 1'b1;
        k = d / D;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_frame_active() || (exp_q.size() > 0);
    endfunction

    function automatic logic [15:0] m_stat();
        return {13'b0, m_ovf, m_busy(), exp_q.size() == DEPTH};
    endfunction

    // Applies the inputs present just before the coming rising edge.
    function automatic void model_edge();
        logic full;
        logic idle;
        logic do_pop;
        m_edge++;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        idle   = (m_edge > m_start + FRAME);
        full   = (exp_q.size() == DEPTH);
        do_pop = idle && (exp_q.size() > 0);
        if (do_pop) begin
            m_byte  = exp_q.pop_front();
            m_start = m_edge;
        end
        if (i_wen && i_addr == TX) begin
            if (full) m_ovf = 1'b1;
            else      exp_q.push_back(i_wdata[7:0]);
        end
        if (i_wen && i_addr == ST && i_wdata[2]) m_ovf = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("tx",    {15'b0, o_tx},   {15'b0, m_tx_exp()});
        chk("busy",  {15'b0, o_busy}, {15'b0, m_busy()});
        chk("rdata", o_rdata, (i_addr == ST) ? m_stat() : 16'h0000);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge i_clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        i_wen = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic store(input logic [15:0] addr, input logic [15:0] data);
        i_wen   = 1'b1;
        i_addr  = addr;
        i_wdata = data;
        step();
        i_wen   = 1'b0;
        i_addr  = 16'h0000;
    endtask

    task automatic read_stat(input string tag, input logic [15:0] exp_v);
        i_wen  = 1'b0;
        i_addr = ST;
        #1;
        chk(tag, o_rdata, exp_v);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset with random inputs
        i_rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_wen   = 1'($urandom_range(0, 1));
            i_addr  = ($urandom_range(0, 1) == 1) ? TX : 16'($urandom);
            i_wdata = 16'($urandom);
            step();
        end
        i_wen  = 1'b0;
        i_addr = ST;
        step();
        chk("rst_tx", {15'b0, o_tx}, 16'h0001);
        chk("rst_busy", {15'b0, o_busy}, 16'h0000);
        chk("rst_stat", o_rdata, 16'h0000);
        i_rst_n = 1'b1;
        i_addr  = 16'h0000;
        idle(3);

        // Single byte 0x55 (upper byte ignored)
        store(TX, 16'h1255);
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k <= 40) chk("single_pattern", {15'b0, o_tx}, 16'(((k - 1) / D) % 2));
            if (k == 40) chk("single_busy_hi", {15'b0, o_busy}, 16'h0001);
            if (k == 41) chk("single_busy_lo", {15'b0, o_busy}, 16'h0000);
        end

        // Burst of 5 fills the FIFO
        for (int b = 1; b <= 5; b++) store(TX, 16'(b));
        read_stat("burst_full", 16'h0003);
        idle(5 * (FRAME + 1) + 10);
        read_stat("burst_done", 16'h0000);

        // Overflow: sixth byte dropped, then cleared by W1C
        for (int b = 1; b <= 6; b++) store(TX, 16'(b));
        read_stat("ovf_set", 16'h0007);
        store(ST, 16'h0004);
        read_stat("ovf_clr", 16'h0003);
        idle(50);
        read_stat("ovf_drain", 16'h0002);
        idle(5 * (FRAME + 1) + 10);

        // Address decode: other addresses do nothing
        store(16'h007A, 16'h00AA);
        store(16'h0000, 16'h00BB);
        i_addr = 16'h007A;
        #1;
        chk("decode_rdata", o_rdata, 16'h0000);
        chk("decode_busy", {15'b0, o_busy}, 16'h0000);
        idle(50);

        // Reset during DATA bit 3 of 0xA5 with two bytes queued
        store(TX, 16'h00A5);
        store(TX, 16'h0011);
        store(TX, 16'h0022);
        idle(15);
        chk("mid_bit3", {15'b0, o_tx}, 16'h0000);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", {15'b0, o_tx}, 16'h0001);
        model_reset();
        idle(3);
        i_rst_n = 1'b1;
        idle(100);
        read_stat("mid_after", 16'h0000);
        chk("mid_idle_busy", {15'b0, o_busy}, 16'h0000);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 9) begin
                store(TX, 16'($urandom));
            end else if (r < 11) begin
                store(ST, 16'($urandom));
            end else if (r < 14) begin
                store(16'($urandom), 16'($urandom));
            end else begin
                i_wen  = 1'b0;
                i_addr = ($urandom_range(0, 3) == 0) ? ST : 16'($urandom);
                step();
            end
        end
        idle(6 * (FRAME + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
